sig_region_reader: RTL and testbench

- Bus initiator that reads a word-aligned memory region [start, end) over the team's req/rsp valid/ready memory interface and streams each word out on a valid/ready output port.
- It is the reading end of the signature flow: the core writes the signature region into the bytewrite SRAM wrapper, and this block reads it back.
- Sits beside the data memory, on a second port or a muxed port, in simulation and FPGA self-check builds.

---
 rtl/sig_region_reader.sv | 183 ++++++++++++++++++
 tb/tb_sig_region_reader.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sig_region_reader.sv
// sig_region_reader
//   Bus initiator that reads the word-aligned region [start, end) over the
//   req/rsp valid/ready memory interface and streams each word out on a
//   valid/ready port. Used to read back the signature region after a run.
//   One request in flight at a time: REQ -> RSP -> OUT per word.
//
// Optional feature (macro SIG_REGION_READER_HALT_POLL_EN):
//   start_i polls HALT_ADDR until it reads 1, then fetches the region bounds
//   from SIG_START_PTR_ADDR / SIG_END_PTR_ADDR instead of using the ports.
//
// Ports:
//   clk_i, rstn_i               clock, synchronous active-low reset
//   start_i                     start pulse (only honoured in IDLE)
//   start_addr_i, end_addr_i    region bounds, low two bits ignored
//   req_*                       read request (data/strobe/write tied off)
//   rsp_*                       read response, rsp_err_i aborts the transfer
//   out_data_o/valid/ready      streamed words
//   busy_o                      not IDLE
//   done_o                      one-cycle completion pulse
//   err_o                       sticky error, cleared by the next start
module sig_region_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] HALT_ADDR          = 'h001F_FFF4,
    parameter logic [ADDR_WIDTH-1:0] SIG_END_PTR_ADDR   = 'h001F_FFF8,
    parameter logic [ADDR_WIDTH-1:0] SIG_START_PTR_ADDR = 'h001F_FFFC
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] start_addr_i,
    input  logic [ADDR_WIDTH-1:0] end_addr_i,
    output logic [ADDR_WIDTH-1:0] req_addr_o,
    output logic [DATA_WIDTH-1:0] req_data_o,
    output logic [3:0]            req_strobe_o,
    output logic                  req_write_o,
    output logic                  req_valid_o,
    input  logic                  req_ready_i,
    input  logic [DATA_WIDTH-1:0] rsp_data_i,
    input  logic                  rsp_err_i,
    input  logic                  rsp_valid_i,
    output logic                  rsp_ready_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_RSP, S_OUT, S_DONE} state_e;
    // What the current REQ/RSP pair is fetching. Only PH_DATA is used
    // when halt polling is compiled out.
    typedef enum logic [1:0] {PH_DATA, PH_HALT, PH_SPTR, PH_EPTR} phase_e;

    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

    state_e                state_q, state_d;
    phase_e                phase_q;
    logic [ADDR_WIDTH-1:0] addr_q, end_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  err_q;

    logic [ADDR_WIDTH-1:0] start_al, end_al, rsp_ptr;
    logic [ADDR_WIDTH:0]   addr_inc;
    logic                  last_word;

    assign start_al  = start_addr_i & WORD_MASK;
    assign end_al    = end_addr_i & WORD_MASK;
    assign rsp_ptr   = ADDR_WIDTH'(rsp_data_i) & WORD_MASK;
    // Extra carry bit catches a wrap past the top of the address space.
    assign addr_inc  = {1'b0, addr_q} + (ADDR_WIDTH+1)'(4);
    assign last_word = addr_inc[ADDR_WIDTH] || (addr_inc[ADDR_WIDTH-1:0] >= end_q);

    // State register
    always_ff @(posedge clk_i) begin
        if (!rstn_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_i) begin
`ifdef SIG_REGION_READER_HALT_POLL_EN
                state_d = S_REQ;
`else
                state_d = (start_al >= end_al) ? S_DONE : S_REQ;
`endif
            end
            S_REQ:  if (req_ready_i) state_d = S_RSP;
            S_RSP:  if (rsp_valid_i) begin
                if (rsp_err_i) state_d = S_DONE;
                else begin
                    case (phase_q)
                        PH_DATA: state_d = S_OUT;
                        // Bounds now known: an empty region ends here.
                        PH_EPTR: state_d = (addr_q >= rsp_ptr) ? S_DONE : S_REQ;
                        default: state_d = S_REQ;
                    endcase
                end
            end
            S_OUT:  if (out_ready_i) state_d = last_word ? S_DONE : S_REQ;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            addr_q <= '0;
            end_q  <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (start_i) begin
                    err_q <= 1'b0;
`ifndef SIG_REGION_READER_HALT_POLL_EN
                    addr_q <= start_al;
                    end_q  <= end_al;
`endif
                end
                S_RSP: if (rsp_valid_i) begin
                    if (rsp_err_i) err_q <= 1'b1;
                    else begin
                        case (phase_q)
                            PH_DATA: data_q <= rsp_data_i;
                            PH_SPTR: addr_q <= rsp_ptr;
                            PH_EPTR: end_q  <= rsp_ptr;
                            default: ;
                        endcase
                    end
                end
                S_OUT: if (out_ready_i) addr_q <= addr_inc[ADDR_WIDTH-1:0];
                default: ;
            endcase
        end
    end

`ifdef SIG_REGION_READER_HALT_POLL_EN
    // Poll sequence: HALT (repeat until 1) -> start pointer -> end pointer -> data.
    // An error response leaves the phase as is; the next start restarts polling.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) phase_q <= PH_DATA;
        else if (state_q == S_IDLE && start_i) phase_q <= PH_HALT;
        else if (state_q == S_RSP && rsp_valid_i && !rsp_err_i) begin
            case (phase_q)
                PH_HALT: if (rsp_data_i == DATA_WIDTH'(1)) phase_q <= PH_SPTR;
                PH_SPTR: phase_q <= PH_EPTR;
                PH_EPTR: phase_q <= PH_DATA;
                default: ;
            endcase
        end
    end
`else
    assign phase_q = PH_DATA;
`endif

    // Outputs
    always_comb begin
        req_valid_o = (state_q == S_REQ);
        rsp_ready_o = (state_q == S_RSP);
        out_valid_o = (state_q == S_OUT);
        done_o      = (state_q == S_DONE);
        busy_o      = (state_q != S_IDLE);
        case (phase_q)
            PH_HALT: req_addr_o = HALT_ADDR;
            PH_SPTR: req_addr_o = SIG_START_PTR_ADDR;
            PH_EPTR: req_addr_o = SIG_END_PTR_ADDR;
            default: req_addr_o = addr_q;
        endcase
    end

    assign out_data_o   = data_q;
    assign err_o        = err_q;
    assign req_data_o   = '0;
    assign req_strobe_o = 4'b0000;
    assign req_write_o  = 1'b0;

endmodule

// File: tb/tb_sig_region_reader.sv
// Bench for sig_region_reader: a memory/sink responder with optional random
// back-pressure, a region reference model, a vector table, hand-written
// stall/reset sequences and randomized regions.
module tb_sig_region_reader;

    localparam logic [31:0] HALT_A = 32'h001F_FFF4;
    localparam logic [31:0] EPTR_A = 32'h001F_FFF8;
    localparam logic [31:0] SPTR_A = 32'h001F_FFFC;

    logic        clk, rstn_i, start_i;
    logic [31:0] start_addr_i, end_addr_i, req_addr_o, req_data_o;
    logic [3:0]  req_strobe_o;
    logic        req_write_o, req_valid_o, req_ready_i;
    logic [31:0] rsp_data_i;
    logic        rsp_err_i, rsp_valid_i, rsp_ready_o;
    logic [31:0] out_data_o;
    logic        out_valid_o, out_ready_i, busy_o, done_o, err_o;

    sig_region_reader dut (
        .clk_i(clk), .rstn_i(rstn_i), .start_i(start_i),
        .start_addr_i(start_addr_i), .end_addr_i(end_addr_i),
        .req_addr_o(req_addr_o), .req_data_o(req_data_o), .req_strobe_o(req_strobe_o),
        .req_write_o(req_write_o), .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
        .rsp_data_i(rsp_data_i), .rsp_err_i(rsp_err_i), .rsp_valid_i(rsp_valid_i),
        .rsp_ready_o(rsp_ready_o), .out_data_o(out_data_o), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] data;
        logic        err;
    } pend_t;

    typedef struct {
        logic [31:0] s;
        logic [31:0] e;
        bit          een;
        logic [31:0] ea;
        int          n_words;
        bit          err;
    } vec_t;

    // knobs written by the main thread, read by the responder
    bit          rand_mode = 1'b0;
    bit          req_block = 1'b0;
    bit          out_block = 1'b0;
    bit          err_en    = 1'b0;
    logic [31:0] err_addr  = 32'h0;

    // observations written by the responder only
    pend_t       pend[$];
    logic [31:0] req_q[$];
    logic [31:0] out_q[$];
    int          done_cnt   = 0;
    int          halt_reads = 0;

    // expectations
    logic [31:0] exp_w[$];
    logic [31:0] exp_a[$];
    bit          exp_err;
    int          ob, rb, db;
    int          n_chk  = 0;
    int          n_fail = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a >= 32'h100 && a < 32'h110) return 32'hA0 + ((a - 32'h100) >> 2);
        if (a == SPTR_A) return 32'h300;
        if (a == EPTR_A) return 32'h308;
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, 32'(act), 32'(exp));
    endtask

    // Reference: every word address from aligned start up to aligned end is
    // read in order; an error response stops the stream without emitting.
    task automatic build_model(input logic [31:0] s, input logic [31:0] e,
                               input bit een, input logic [31:0] ea);
        longint unsigned a, lim;
        a   = longint'(s & 32'hFFFF_FFFC);
        lim = longint'(e & 32'hFFFF_FFFC);
        exp_w.delete();
        exp_a.delete();
        exp_err = 1'b0;
        while (a < lim) begin
            exp_a.push_back(a[31:0]);
            if (een && a[31:0] == ea) begin
                exp_err = 1'b1;
                break;
            end
            exp_w.push_back(mem_word(a[31:0]));
            a += 4;
        end
    endtask

    // Memory + sink. Inputs change on the falling edge; the handshakes that
    // the next rising edge will complete are recorded just after.
    initial begin
        pend_t p;
        req_ready_i = 1'b0; rsp_valid_i = 1'b0; rsp_data_i = '0;
        rsp_err_i = 1'b0; out_ready_i = 1'b0;
        forever begin
            @(negedge clk);
            req_ready_i = !req_block && (!rand_mode || $urandom_range(0, 3) != 0);
            out_ready_i = !out_block && (!rand_mode || $urandom_range(0, 2) != 0);
            if (pend.size() > 0) begin
                rsp_valid_i = rsp_valid_i || !rand_mode || ($urandom_range(0, 1) == 1);
                rsp_data_i  = pend[0].data;
                rsp_err_i   = pend[0].err;
            end else begin
                rsp_valid_i = 1'b0;
                rsp_data_i  = 32'hDEAD_BEEF;
                rsp_err_i   = 1'b0;
            end
            #1;
            if (!rstn_i) pend.delete();
            else begin
                if (rsp_valid_i && rsp_ready_o) pend.delete(0);
                if (req_valid_o && req_ready_i) begin
                    p.data = mem_word(req_addr_o);
`ifdef SIG_REGION_READER_HALT_POLL_EN
                    if (req_addr_o == HALT_A) begin
                        halt_reads++;
                        p.data = (halt_reads >= 4) ? 32'h1 : 32'h0;
                    end
`endif
                    p.err = err_en && (req_addr_o == err_addr);
                    pend.push_back(p);
                    req_q.push_back(req_addr_o);
                end
                if (out_valid_o && out_ready_i) out_q.push_back(out_data_o);
                if (done_o) done_cnt++;
            end
        end
    end

    task automatic chk_zero(input string name);
        chk({name, " req_addr"}, req_addr_o, 32'h0);
        chk({name, " req_data"}, req_data_o, 32'h0);
        chk({name, " strobe"}, 32'(req_strobe_o), 32'h0);
        chk1({name, " write"}, req_write_o, 1'b0);
        chk1({name, " req_valid"}, req_valid_o, 1'b0);
        chk1({name, " rsp_ready"}, rsp_ready_o, 1'b0);
        chk({name, " out_data"}, out_data_o, 32'h0);
        chk1({name, " out_valid"}, out_valid_o, 1'b0);
        chk1({name, " busy"}, busy_o, 1'b0);
        chk1({name, " done"}, done_o, 1'b0);
        chk1({name, " err"}, err_o, 1'b0);
    endtask

    task automatic pulse_start(input logic [31:0] s, input logic [31:0] e);
        ob = out_q.size(); rb = req_q.size(); db = done_cnt;
        start_addr_i = s; end_addr_i = e; start_i = 1'b1;
        @(posedge clk); #2;
        start_i = 1'b0;
        chk1("start clears err", err_o, 1'b0);
    endtask

    task automatic start_region(input logic [31:0] s, input logic [31:0] e,
                                input bit een, input logic [31:0] ea);
        build_model(s, e, een, ea);
        err_en = een; err_addr = ea;
        pulse_start(s, e);
    endtask

    task automatic finish_region(input string name);
        int cyc, n;
        cyc = 0;
        while (busy_o && cyc < 3000) begin
            @(posedge clk); #2;
            cyc++;
        end
        chk1({name, " idle"}, busy_o, 1'b0);
        n = out_q.size() - ob;
        chk({name, " nwords"}, 32'(n), 32'(exp_w.size()));
        for (int i = 0; i < n && i < exp_w.size(); i++)
            chk($sformatf("%s word%0d", name, i), out_q[ob + i], exp_w[i]);
        n = req_q.size() - rb;
        chk({name, " nreq"}, 32'(n), 32'(exp_a.size()));
        for (int i = 0; i < n && i < exp_a.size(); i++)
            chk($sformatf("%s req%0d", name, i), req_q[rb + i], exp_a[i]);
        chk({name, " done pulses"}, 32'(done_cnt - db), 32'h1);
        chk1({name, " err"}, err_o, exp_err);
    endtask

    task automatic wait_cond_out(input int target, input bit want_rsp, input string name);
        int cyc;
        cyc = 0;
        while (!(out_q.size() >= target && (!want_rsp || rsp_ready_o)) && cyc < 500) begin
            @(posedge clk); #2;
            cyc++;
        end
        chk({name, " reached"}, 32'(cyc < 500), 32'h1);
    endtask

    vec_t tbl[7];

    initial begin
        logic [31:0] s, e, ea, d;
        bit          een;
        int          cyc;

        rstn_i = 1'b0; start_i = 1'b0; start_addr_i = '0; end_addr_i = '0;
        repeat (3) @(posedge clk);
        #2;
        chk_zero("reset");
        rstn_i = 1'b1;
        @(posedge clk); #2;

`ifdef SIG_REGION_READER_HALT_POLL_EN
        // Halt cell reads 0 three times, then 1; pointers give 0x300 / 0x308.
        err_en = 1'b0;
        pulse_start(32'h0, 32'h0);
        exp_a = '{HALT_A, HALT_A, HALT_A, HALT_A, SPTR_A, EPTR_A, 32'h300, 32'h304};
        exp_w = '{mem_word(32'h300), mem_word(32'h304)};
        exp_err = 1'b0;
        finish_region("halt_poll");
`else
        tbl[0] = '{32'h100,      32'h110,      1'b0, 32'h0,   4, 1'b0};
        tbl[1] = '{32'h100,      32'h110,      1'b1, 32'h108, 2, 1'b1};
        tbl[2] = '{32'h103,      32'h10B,      1'b0, 32'h0,   2, 1'b0};
        tbl[3] = '{32'h200,      32'h200,      1'b0, 32'h0,   0, 1'b0};
        tbl[4] = '{32'h300,      32'h200,      1'b0, 32'h0,   0, 1'b0};
        tbl[5] = '{32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b0, 32'h0, 3, 1'b0};
        tbl[6] = '{32'h100,      32'h104,      1'b1, 32'h100, 0, 1'b1};
        for (int k = 0; k < 7; k++) begin
            start_region(tbl[k].s, tbl[k].e, tbl[k].een, tbl[k].ea);
            finish_region($sformatf("vec%0d", k));
            chk($sformatf("vec%0d table nwords", k), 32'(out_q.size() - ob), 32'(tbl[k].n_words));
            chk1($sformatf("vec%0d table err", k), err_o, tbl[k].err);
        end

        // Empty region: done the cycle after start, nothing requested.
        start_addr_i = 32'h200; end_addr_i = 32'h200; start_i = 1'b1;
        @(posedge clk); #2;
        start_i = 1'b0;
        chk1("empty done", done_o, 1'b1);
        chk1("empty req_valid", req_valid_o, 1'b0);
        @(posedge clk); #2;
        chk1("empty busy after", busy_o, 1'b0);
        chk1("empty done after", done_o, 1'b0);

        // Request stall: address held while req_ready is low.
        req_block = 1'b1;
        start_region(32'h100, 32'h110, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            chk1("reqstall valid", req_valid_o, 1'b1);
            chk("reqstall addr", req_addr_o, 32'h100);
            @(posedge clk); #2;
        end
        req_block = 1'b0;
        finish_region("reqstall");

        // Output stall on the second word.
        start_region(32'h100, 32'h110, 1'b0, 32'h0);
        wait_cond_out(ob + 1, 1'b0, "outstall first");
        out_block = 1'b1;
        cyc = 0;
        while (!out_valid_o && cyc < 50) begin
            @(posedge clk); #2;
            cyc++;
        end
        d = out_data_o;
        chk("outstall word", d, 32'hA1);
        for (int i = 0; i < 7; i++) begin
            chk1("outstall valid", out_valid_o, 1'b1);
            chk("outstall data held", out_data_o, d);
            chk1("outstall no req", req_valid_o, 1'b0);
            @(posedge clk); #2;
        end
        out_block = 1'b0;
        finish_region("outstall");

        // Reset while waiting for the second response.
        start_region(32'h100, 32'h110, 1'b0, 32'h0);
        wait_cond_out(ob + 1, 1'b1, "rst in rsp");
        rstn_i = 1'b0;
        @(posedge clk); #2;
        chk_zero("midrsp_rst");
        rstn_i = 1'b1;
        @(posedge clk); #2;
        chk1("post rst busy", busy_o, 1'b0);
        start_region(32'h100, 32'h110, 1'b0, 32'h0);
        finish_region("after_rst");

        // Randomized regions with random back-pressure and errors.
        rand_mode = 1'b1;
        for (int k = 0; k < 25; k++) begin
            s   = 32'h100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            e   = s + 32'($urandom_range(0, 32));
            een = ($urandom_range(0, 3) == 0);
            ea  = (s & 32'hFFFF_FFFC) + 32'(4 * $urandom_range(0, 7));
            start_region(s, e, een, ea);
            finish_region($sformatf("rnd%0d", k));
        end
        rand_mode = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
